// File: rtl/dsp_pkg.sv
// OPMODE field encodings and default widths shared by the DSP post-adder stage.
package dsp_pkg;

    localparam int M_WIDTH_DEFAULT = 36;
    localparam int P_WIDTH_DEFAULT = 48;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_C    = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    localparam int OP_X_LSB = 0;
    localparam int OP_Z_LSB = 2;
    localparam int OP_CIN   = 4;
    localparam int OP_SUB   = 5;

endpackage

// File: rtl/post_adder_mux.sv
// Combinational X/Z operand selection and (P_WIDTH+1)-bit add/subtract.
// The overflow output exists only when POST_ADD_OVF_EN is defined.
module post_adder_mux
    import dsp_pkg::*;
#(
    parameter int M_WIDTH = M_WIDTH_DEFAULT,
    parameter int P_WIDTH = P_WIDTH_DEFAULT
) (
    input  logic [5:0]         opmode,
    input  logic               acc_clr,
    input  logic [M_WIDTH-1:0] m,
    input  logic [P_WIDTH-1:0] c,
    input  logic [P_WIDTH-1:0] pcin,
    input  logic [P_WIDTH-1:0] p_fb,
`ifdef POST_ADD_OVF_EN
    output logic               ovf,
`endif
    output logic [P_WIDTH:0]   sum
);

    logic [P_WIDTH-1:0] fb;
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] z;
    logic [P_WIDTH:0]   cin_ext;
    logic               sub;

    assign fb      = acc_clr ? '0 : p_fb;
    assign sub     = opmode[OP_SUB];
    assign cin_ext = {{P_WIDTH{1'b0}}, opmode[OP_CIN]};

    always_comb begin
        x = '0;
        case (opmode[OP_X_LSB +: 2])
            X_ZERO:  x = '0;
            X_M:     x = {{(P_WIDTH-M_WIDTH){m[M_WIDTH-1]}}, m};
            X_P:     x = fb;
            default: x = c;
        endcase
    end

    always_comb begin
        z = '0;
        case (opmode[OP_Z_LSB +: 2])
            Z_ZERO:  z = '0;
            Z_PCIN:  z = pcin;
            Z_P:     z = fb;
            default: z = c;
        endcase
    end

    // Operands are zero-extended so bit P_WIDTH is the raw carry (or borrow) out.
    assign sum = sub ? ({1'b0, z} - ({1'b0, x} + cin_ext))
                     : ({1'b0, z} + {1'b0, x} + cin_ext);

`ifdef POST_ADD_OVF_EN
    // Subtraction flips the effective sign of X.
    assign ovf = (sum[P_WIDTH-1] != z[P_WIDTH-1]) &&
                 (sub ? (z[P_WIDTH-1] != x[P_WIDTH-1])
                      : (z[P_WIDTH-1] == x[P_WIDTH-1]));
`endif

endmodule

// File: rtl/post_adder_acc.sv
// DSP post-adder/accumulator: P register, valid flop and PREG bypass.
// Define POST_ADD_OVF_EN to add the sticky OVERFLOW output.
module post_adder_acc
    import dsp_pkg::*;
#(
    parameter int M_WIDTH = M_WIDTH_DEFAULT,
    parameter int P_WIDTH = P_WIDTH_DEFAULT,
    parameter int PREG    = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CEP,
    input  logic               IN_VALID,
    input  logic               ACC_CLR,
    input  logic [5:0]         OPMODE,
    input  logic [M_WIDTH-1:0] M,
    input  logic [P_WIDTH-1:0] C,
    input  logic [P_WIDTH-1:0] PCIN,
    output logic [P_WIDTH-1:0] P,
    output logic [P_WIDTH-1:0] PCOUT,
    output logic               CARRYOUT,
`ifdef POST_ADD_OVF_EN
    output logic               OVERFLOW,
`endif
    output logic               P_VALID
);

    logic [P_WIDTH-1:0] p_fb;
    logic [P_WIDTH:0]   sum;
`ifdef POST_ADD_OVF_EN
    logic               ovf;
`endif

    post_adder_mux #(
        .M_WIDTH (M_WIDTH),
        .P_WIDTH (P_WIDTH)
    ) u_mux (
        .opmode  (OPMODE),
        .acc_clr (ACC_CLR),
        .m       (M),
        .c       (C),
        .pcin    (PCIN),
        .p_fb    (p_fb),
`ifdef POST_ADD_OVF_EN
        .ovf     (ovf),
`endif
        .sum     (sum)
    );

    generate
        if (PREG != 0) begin : g_preg
            logic [P_WIDTH-1:0] p_q;
            logic               co_q;
            logic               valid_q;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    p_q     <= '0;
                    co_q    <= 1'b0;
                    valid_q <= 1'b0;
                end else if (CEP) begin
                    valid_q <= IN_VALID;
                    if (IN_VALID) begin
                        p_q  <= sum[P_WIDTH-1:0];
                        co_q <= sum[P_WIDTH];
                    end
                end
            end

            assign p_fb     = p_q;
            assign P        = p_q;
            assign CARRYOUT = co_q;
            assign P_VALID  = valid_q;

`ifdef POST_ADD_OVF_EN
            logic ovf_q;

            // ACC_CLR starts a new accumulation, so the sticky history restarts too.
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    ovf_q <= 1'b0;
                end else if (CEP && IN_VALID) begin
                    ovf_q <= ACC_CLR ? ovf : (ovf_q | ovf);
                end
            end

            assign OVERFLOW = ovf_q;
`endif
        end else begin : g_bypass
            assign p_fb     = '0;
            assign P        = sum[P_WIDTH-1:0];
            assign CARRYOUT = sum[P_WIDTH];
            assign P_VALID  = IN_VALID;
`ifdef POST_ADD_OVF_EN
            assign OVERFLOW = ovf;
`endif
        end
    endgenerate

    assign PCOUT = P;

endmodule

// File: tb/tb_post_adder_acc.sv
// Directed bench for post_adder_acc: vector table on a PREG=1 instance plus
// hand-written reset and PREG=0 sequences.
module tb_post_adder_acc;

    logic        CLK;
    logic        RST;
    logic        CEP;
    logic        IN_VALID;
    logic        ACC_CLR;
    logic [5:0]  OPMODE;
    logic [35:0] M;
    logic [47:0] C;
    logic [47:0] PCIN;

    logic [47:0] p1, pcout1, p2, pcout2;
    logic        co1, valid1, co2, valid2;
`ifdef POST_ADD_OVF_EN
    logic        ovf1, ovf2;
`endif

    int n_pass;
    int n_total;

    post_adder_acc #(.M_WIDTH(36), .P_WIDTH(48), .PREG(1)) dut_reg (
        .CLK(CLK), .RST(RST), .CEP(CEP), .IN_VALID(IN_VALID), .ACC_CLR(ACC_CLR),
        .OPMODE(OPMODE), .M(M), .C(C), .PCIN(PCIN),
        .P(p1), .PCOUT(pcout1), .CARRYOUT(co1),
`ifdef POST_ADD_OVF_EN
        .OVERFLOW(ovf1),
`endif
        .P_VALID(valid1)
    );

    post_adder_acc #(.M_WIDTH(36), .P_WIDTH(48), .PREG(0)) dut_comb (
        .CLK(CLK), .RST(RST), .CEP(CEP), .IN_VALID(IN_VALID), .ACC_CLR(ACC_CLR),
        .OPMODE(OPMODE), .M(M), .C(C), .PCIN(PCIN),
        .P(p2), .PCOUT(pcout2), .CARRYOUT(co2),
`ifdef POST_ADD_OVF_EN
        .OVERFLOW(ovf2),
`endif
        .P_VALID(valid2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        cep;
        logic        iv;
        logic        clr;
        logic [5:0]  op;
        logic [35:0] m;
        logic [47:0] c;
        logic [47:0] pcin;
        logic [47:0] exp_p;
        logic        exp_co;
        logic        exp_v;
        logic        exp_ovf;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vec [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic drive(input logic cep, input logic iv, input logic clr, input logic [5:0] op,
                         input logic [35:0] m, input logic [47:0] c, input logic [47:0] pcin);
        CEP = cep; IN_VALID = iv; ACC_CLR = clr; OPMODE = op; M = m; C = c; PCIN = pcin;
    endtask

    initial begin
        // opmode = {SUB, CIN, Z[1:0], X[1:0]}
        //            cep iv clr op     m               c                  pcin     exp_p              co v ovf
        vec[0]  = '{1, 1, 1, 6'h09, 36'd5,          48'd0,             48'd0,   48'd5,             0, 1, 0};
        vec[1]  = '{1, 1, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd10,            0, 1, 0};
        vec[2]  = '{1, 1, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd15,            0, 1, 0};
        vec[3]  = '{1, 1, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd20,            0, 1, 0};
        vec[4]  = '{0, 1, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd20,            0, 1, 0};
        vec[5]  = '{0, 1, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd20,            0, 1, 0};
        vec[6]  = '{0, 1, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd20,            0, 1, 0};
        vec[7]  = '{1, 1, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd25,            0, 1, 0};
        vec[8]  = '{1, 0, 0, 6'h09, 36'd5,          48'd0,             48'd0,   48'd25,            0, 0, 0};
        vec[9]  = '{1, 1, 0, 6'h3D, 36'd3,          48'd10,            48'd0,   48'd6,             0, 1, 0};
        vec[10] = '{1, 1, 0, 6'h01, 36'hF_FFFF_FFFF, 48'd0,            48'd0,   48'hFFFF_FFFF_FFFF, 0, 1, 0};
        vec[11] = '{1, 1, 0, 6'h1C, 36'd0,          48'hFFFF_FFFF_FFFF, 48'd0,  48'd0,             1, 1, 0};
        vec[12] = '{1, 1, 0, 6'h1C, 36'd0,          48'h7FFF_FFFF_FFFF, 48'd0,  48'h8000_0000_0000, 0, 1, 1};
        vec[13] = '{1, 0, 0, 6'h1C, 36'd0,          48'h7FFF_FFFF_FFFF, 48'd0,  48'h8000_0000_0000, 0, 0, 1};
        vec[14] = '{1, 1, 0, 6'h05, 36'd7,          48'd0,             48'd100, 48'd107,           0, 1, 1};
        vec[15] = '{1, 1, 1, 6'h1A, 36'd0,          48'd0,             48'd0,   48'd1,             0, 1, 0};
        vec[16] = '{1, 1, 1, 6'h3A, 36'd0,          48'd0,             48'd0,   48'hFFFF_FFFF_FFFF, 1, 1, 0};

        n_pass  = 0;
        n_total = 0;
        RST = 1'b1;
        drive(0, 0, 0, 6'h00, 36'd0, 48'd0, 48'd0);

        #2;
        chk("reset_p", {16'd0, p1}, 64'd0);
        chk("reset_pcout", {16'd0, pcout1}, 64'd0);
        chk("reset_co", {63'd0, co1}, 64'd0);
        chk("reset_valid", {63'd0, valid1}, 64'd0);
`ifdef POST_ADD_OVF_EN
        chk("reset_ovf", {63'd0, ovf1}, 64'd0);
`endif
        #6;
        RST = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vec[i].cep, vec[i].iv, vec[i].clr, vec[i].op, vec[i].m, vec[i].c, vec[i].pcin);
            @(posedge CLK);
            #1;
            chk($sformatf("vec%0d_p", i), {16'd0, p1}, {16'd0, vec[i].exp_p});
            chk($sformatf("vec%0d_pcout", i), {16'd0, pcout1}, {16'd0, vec[i].exp_p});
            chk($sformatf("vec%0d_co", i), {63'd0, co1}, {63'd0, vec[i].exp_co});
            chk($sformatf("vec%0d_valid", i), {63'd0, valid1}, {63'd0, vec[i].exp_v});
`ifdef POST_ADD_OVF_EN
            chk($sformatf("vec%0d_ovf", i), {63'd0, ovf1}, {63'd0, vec[i].exp_ovf});
`endif
        end

        // Asynchronous reset in the middle of an accumulation.
        drive(1, 1, 0, 6'h1C, 36'd0, 48'h122, 48'd0);
        @(posedge CLK);
        #1;
        chk("pre_rst_p", {16'd0, p1}, 64'h123);
        drive(1, 1, 0, 6'h09, 36'd5, 48'd0, 48'd0);
        #3;
        RST = 1'b1;
        #1;
        chk("async_rst_p", {16'd0, p1}, 64'd0);
        chk("async_rst_pcout", {16'd0, pcout1}, 64'd0);
        chk("async_rst_co", {63'd0, co1}, 64'd0);
        chk("async_rst_valid", {63'd0, valid1}, 64'd0);
        #1;
        RST = 1'b0;

        // Cascade; the bypass instance answers in the same cycle.
        drive(1, 1, 0, 6'h05, 36'd7, 48'd0, 48'd100);
        #1;
        chk("bypass_cascade_p", {16'd0, p2}, 64'd107);
        chk("bypass_cascade_pcout", {16'd0, pcout2}, 64'd107);
        chk("bypass_cascade_valid", {63'd0, valid2}, 64'd1);
        @(posedge CLK);
        #1;
        chk("post_rst_p", {16'd0, p1}, 64'd107);
        chk("post_rst_valid", {63'd0, valid1}, 64'd1);

        // Bypass has no P register, so feedback reads zero.
        drive(1, 0, 0, 6'h09, 36'd5, 48'd0, 48'd0);
        #1;
        chk("bypass_fb_p", {16'd0, p2}, 64'd5);
        chk("bypass_valid_low", {63'd0, valid2}, 64'd0);
        drive(1, 1, 0, 6'h1C, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0);
        #1;
        chk("bypass_wrap_p", {16'd0, p2}, 64'd0);
        chk("bypass_wrap_co", {63'd0, co2}, 64'd1);
`ifdef POST_ADD_OVF_EN
        drive(1, 1, 0, 6'h1C, 36'd0, 48'h7FFF_FFFF_FFFF, 48'd0);
        #1;
        chk("bypass_ovf", {63'd0, ovf2}, 64'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
